pll_reset_ctrl: RTL and testbench

PLL_RESET_CTRL -- requirements
Module: pll_reset_ctrl

---
 rtl/pll_ctrl_pkg.sv | 26 ++
 rtl/sync_2ff.sv | 31 +++
 rtl/pll_reset_ctrl.sv | 146 ++++++++++++++
 tb/tb_pll_reset_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/pll_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pll_ctrl_pkg : shared types and constants for the PLL reset controller
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package pll_ctrl_pkg;

  localparam int CNT_W   = 16;
  localparam int RETRY_W = 4;

  typedef enum logic [2:0] {
    ST_HOLD      = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } pll_state_e;

  function automatic logic [RETRY_W-1:0] sat_inc(input logic [RETRY_W-1:0] val);
    return (val == {RETRY_W{1'b1}}) ? val : val + RETRY_W'(1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff : two-flop synchronizer, async active-low reset to 0
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sync_2ff (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

`default_nettype wire

// File: rtl/pll_reset_ctrl.sv
// ---------------------------------------------------------------------------
// pll_reset_ctrl : PLL reset / lock-qualification sequencer with retry and fail
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pll_reset_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int RST_HOLD     = 1000,
  parameter int LOCK_STABLE  = 5000,
  parameter int LOCK_TIMEOUT = 50000,
  parameter int MAX_RETRY    = 3
) (
  input  logic               refclk,
  input  logic               rst_n,
  input  logic               pll_locked,
  input  logic               req_reconfig,
  output logic               pll_rst,
  output logic               core_reset,
  output logic               sys_ready,
  output logic               fail,
  output logic [RETRY_W-1:0] retry_count
);

  if (RST_HOLD < 1 || RST_HOLD > 2**CNT_W ||
      LOCK_STABLE < 1 || LOCK_STABLE > 2**CNT_W ||
      LOCK_TIMEOUT < 1 || LOCK_TIMEOUT > 2**CNT_W ||
      MAX_RETRY < 1 || MAX_RETRY > 15) begin : g_bad_params
    $fatal(1, "pll_reset_ctrl: parameter out of range");
  end

  localparam logic [CNT_W-1:0]   c_hold_last    = CNT_W'(RST_HOLD - 1);
  localparam logic [CNT_W-1:0]   c_stable_last  = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0]   c_timeout_last = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [RETRY_W-1:0] c_max_retry    = RETRY_W'(MAX_RETRY);

  logic w_rst_sync;
  logic w_locked_s;

  sync_2ff u_rst_sync (
    .clk_i  (refclk),
    .rst_ni (rst_n),
    .d_i    (1'b1),
    .q_o    (w_rst_sync)
  );

  sync_2ff u_lock_sync (
    .clk_i  (refclk),
    .rst_ni (rst_n),
    .d_i    (pll_locked),
    .q_o    (w_locked_s)
  );

  pll_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic [RETRY_W-1:0] w_retry_inc;
  logic               pll_rst_q, core_reset_q, sys_ready_q, fail_q;

  assign w_retry_inc = sat_inc(retry_q);

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_HOLD;
      cnt_q        <= '0;
      retry_q      <= '0;
      pll_rst_q    <= 1'b1;
      core_reset_q <= 1'b1;
      sys_ready_q  <= 1'b0;
      fail_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      retry_q      <= retry_d;
      pll_rst_q    <= (state_d == ST_HOLD) || (state_d == ST_FAIL);
      core_reset_q <= (state_d != ST_RUN);
      sys_ready_q  <= (state_d == ST_RUN);
      fail_q       <= (state_d == ST_FAIL);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    retry_d = retry_q;

    if (req_reconfig) begin
      state_d = ST_HOLD;
      cnt_d   = '0;
      retry_d = '0;
    end else begin
      unique case (state_q)
        ST_HOLD: begin
          // The hold window only starts counting once reset release is synchronized.
          if (!w_rst_sync) begin
            cnt_d = '0;
          end else if (cnt_q == c_hold_last) begin
            state_d = ST_WAIT_LOCK;
          end
        end
        ST_WAIT_LOCK: begin
          if (w_locked_s) begin
            state_d = ST_STABLE;
          end else if (cnt_q == c_timeout_last) begin
            retry_d = w_retry_inc;
            state_d = (w_retry_inc == c_max_retry) ? ST_FAIL : ST_HOLD;
          end
        end
        ST_STABLE: begin
          if (!w_locked_s) begin
            state_d = ST_WAIT_LOCK;
          end else if (cnt_q == c_stable_last) begin
            state_d = ST_RUN;
            retry_d = '0;
          end
        end
        ST_RUN: begin
          cnt_d = cnt_q;
          if (!w_locked_s) begin
            state_d = ST_HOLD;
          end
        end
        ST_FAIL: begin
          cnt_d = cnt_q;
        end
        default: begin
          state_d = ST_HOLD;
        end
      endcase

      if (state_d != state_q) begin
        cnt_d = '0;
      end
    end
  end

  assign pll_rst     = pll_rst_q;
  assign core_reset  = core_reset_q;
  assign sys_ready   = sys_ready_q;
  assign fail        = fail_q;
  assign retry_count = retry_q;

endmodule

`default_nettype wire

// File: tb/tb_pll_reset_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pll_reset_ctrl : directed self-checking bench for pll_reset_ctrl
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_pll_reset_ctrl;

  localparam int LIMIT = 200;

  logic       refclk = 1'b0;
  logic       rst_n;
  logic       pll_locked;
  logic       req_reconfig;
  logic       pll_rst;
  logic       core_reset;
  logic       sys_ready;
  logic       fail;
  logic [3:0] retry_count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 refclk = ~refclk;

  pll_reset_ctrl #(
    .RST_HOLD     (4),
    .LOCK_STABLE  (8),
    .LOCK_TIMEOUT (20),
    .MAX_RETRY    (2)
  ) u_dut (
    .refclk       (refclk),
    .rst_n        (rst_n),
    .pll_locked   (pll_locked),
    .req_reconfig (req_reconfig),
    .pll_rst      (pll_rst),
    .core_reset   (core_reset),
    .sys_ready    (sys_ready),
    .fail         (fail),
    .retry_count  (retry_count)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge refclk);
    @(negedge refclk);
  endtask

  task automatic wait_pll_rst_low(output int n);
    n = 0;
    while (pll_rst !== 1'b0 && n < LIMIT) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_sys_ready(output int n);
    n = 0;
    while (sys_ready !== 1'b1 && n < LIMIT) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_retry(input logic [3:0] val, output int n);
    n = 0;
    while (retry_count !== val && n < LIMIT) begin
      tick();
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    rst_n        = 1'b0;
    pll_locked   = 1'b0;
    req_reconfig = 1'b0;
    repeat (3) tick();

    check_eq("rst_pll_rst",    pll_rst,     1);
    check_eq("rst_core_reset", core_reset,  1);
    check_eq("rst_sys_ready",  sys_ready,   0);
    check_eq("rst_fail",       fail,        0);
    check_eq("rst_retry",      retry_count, 0);

    // Nominal: 2 sync edges overlap the first hold count, pll_rst falls on edge 6.
    rst_n = 1'b1;
    wait_pll_rst_low(n);
    check_eq("nom_hold_edges", n, 6);
    check_eq("nom_core_in_wait", core_reset, 1);
    repeat (10) tick();
    pll_locked = 1'b1;
    for (int i = 1; i <= 11; i++) begin
      tick();
      if (i == 10) begin
        check_eq("nom_sys_before_run",  sys_ready,  0);
        check_eq("nom_core_before_run", core_reset, 1);
      end
    end
    check_eq("nom_sys_run",  sys_ready,   1);
    check_eq("nom_core_run", core_reset,  0);
    check_eq("nom_pll_run",  pll_rst,     0);
    check_eq("nom_retry",    retry_count, 0);

    // Lock loss in RUN: sync (2) + transition (1).
    pll_locked = 1'b0;
    repeat (2) tick();
    check_eq("loss_sys_still", sys_ready, 1);
    tick();
    check_eq("loss_sys",  sys_ready,  0);
    check_eq("loss_core", core_reset, 1);
    check_eq("loss_pll",  pll_rst,    1);
    wait_pll_rst_low(n);
    check_eq("loss_hold_len", n, 4);
    check_eq("loss_retry", retry_count, 0);

    // Glitch in STABLE: lock raised, STABLE entered edge 3, drop after edge 7.
    pll_locked = 1'b1;
    repeat (7) tick();
    check_eq("gl_sys_stable", sys_ready, 0);
    pll_locked = 1'b0;
    repeat (3) tick();
    pll_locked = 1'b1;
    check_eq("gl_retry", retry_count, 0);
    check_eq("gl_pll",   pll_rst,     0);
    check_eq("gl_sys",   sys_ready,   0);
    wait_sys_ready(n);
    check_eq("gl_fresh_window", n, 11);
    check_eq("gl_retry_run", retry_count, 0);

    // Timeout path: HOLD at edge 3, WAIT from edge 7, timeout at edge 27.
    pll_locked = 1'b0;
    wait_retry(4'd1, n);
    check_eq("to_first_timeout", n, 27);
    check_eq("to_pll_1", pll_rst, 1);
    check_eq("to_fail_1", fail, 0);
    wait_pll_rst_low(n);
    check_eq("to_hold_len", n, 4);
    repeat (19) tick();
    check_eq("to_fail_pre", fail, 0);
    check_eq("to_retry_pre", retry_count, 1);
    tick();
    check_eq("to_retry_2", retry_count, 2);
    check_eq("to_fail",    fail,        1);
    check_eq("to_pll_fail", pll_rst,    1);
    check_eq("to_sys_fail", sys_ready,  0);
    check_eq("to_core_fail", core_reset, 1);
    repeat (5) tick();
    check_eq("to_fail_sticky", fail, 1);
    req_reconfig = 1'b1;
    tick();
    req_reconfig = 1'b0;
    check_eq("rc_fail",  fail,        0);
    check_eq("rc_retry", retry_count, 0);
    check_eq("rc_pll",   pll_rst,     1);
    wait_pll_rst_low(n);
    check_eq("rc_hold_len", n, 4);

    // Reconfig coincident with the second timeout.
    wait_retry(4'd1, n);
    check_eq("sim_first_timeout", n, 20);
    wait_pll_rst_low(n);
    check_eq("sim_hold_len", n, 4);
    repeat (19) tick();
    req_reconfig = 1'b1;
    tick();
    req_reconfig = 1'b0;
    check_eq("sim_fail",  fail,        0);
    check_eq("sim_retry", retry_count, 0);
    check_eq("sim_pll",   pll_rst,     1);
    wait_pll_rst_low(n);
    check_eq("sim_hold_len2", n, 4);

    // Async reset mid-STABLE: outputs must go to reset values before the next edge.
    pll_locked = 1'b1;
    repeat (5) tick();
    check_eq("ar_pll_before", pll_rst, 0);
    #2 rst_n = 1'b0;
    #1;
    check_eq("ar_pll",   pll_rst,     1);
    check_eq("ar_core",  core_reset,  1);
    check_eq("ar_sys",   sys_ready,   0);
    check_eq("ar_fail",  fail,        0);
    check_eq("ar_retry", retry_count, 0);
    tick();
    rst_n = 1'b1;
    wait_pll_rst_low(n);
    check_eq("ar_hold_edges", n, 6);
    wait_sys_ready(n);
    check_eq("ar_run_edges", n, 9);
    check_eq("ar_core_run", core_reset, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
